// File: rtl/processor.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback
// all complete in one clock; one instruction retires per rising edge while rst=1.
// Ports:
//   clk - single clock, all state updates on the rising edge
//   rst - asynchronous active-low reset; forces PC to 0, memories keep contents
// Memories (inst_mem_i.mem, reg_file_i.reg_mem, data_mem_i.data_mem) are
// preloaded and inspected hierarchically.

// Instruction ROM with combinational word read; out-of-range fetches return NOP.
// The write port exists so the array has a hardware source; the core ties it off.
module inst_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        load_en,
    input  logic [29:0] load_word,
    input  logic [31:0] load_data,
    input  logic [29:0] word,
    output logic [31:0] rdata_c
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (load_en && (32'(load_word) < DEPTH)) mem[load_word[AW-1:0]] <= load_data;
    end

    always_comb begin
        rdata_c = 32'h0000_0013;
        if (32'(word) < DEPTH) rdata_c = mem[word[AW-1:0]];
    end
endmodule

// 32x32 register file: two combinational read ports, one clocked write port; x0 is hardwired 0.
module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1_c,
    output logic [31:0] rdata2_c
);
    logic [31:0] reg_mem [0:31];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) reg_mem[waddr] <= wdata;
    end

    assign rdata1_c = (raddr1 == 5'd0) ? 32'd0 : reg_mem[raddr1];
    assign rdata2_c = (raddr2 == 5'd0) ? 32'd0 : reg_mem[raddr2];
endmodule

// Word-addressed data RAM: out-of-range loads read 0, out-of-range stores are dropped.
module data_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_c
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] data_mem [0:DEPTH-1];
    logic        in_range;

    assign in_range = (32'(word) < DEPTH);

    always_ff @(posedge clk) begin
        if (we && in_range) data_mem[word[AW-1:0]] <= wdata;
    end

    assign rdata_c = in_range ? data_mem[word[AW-1:0]] : 32'd0;
endmodule

module processor #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0] pc, pc_next, pc_plus4, instr;
    logic [31:0] rs1_val, rs2_val, rd_data, dmem_addr, dmem_rdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, alu_b, alu_res;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  shamt;
    logic        rd_we, dmem_we, br_taken;

    inst_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_i (
        .clk(clk), .load_en(1'b0), .load_word(30'd0), .load_data(32'd0),
        .word(30'(pc >> 2)), .rdata_c(instr)
    );

    // Writes are gated by rst so nothing retires while reset is held.
    reg_file reg_file_i (
        .clk(clk), .we(rd_we & rst), .waddr(instr[11:7]), .wdata(rd_data),
        .raddr1(instr[19:15]), .raddr2(instr[24:20]),
        .rdata1_c(rs1_val), .rdata2_c(rs2_val)
    );

    data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_i (
        .clk(clk), .we(dmem_we & rst), .word(30'(dmem_addr >> 2)),
        .wdata(rs2_val), .rdata_c(dmem_rdata)
    );

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u    = {instr[31:12], 12'd0};
    assign pc_plus4 = pc + 32'd4;

    // Shared ALU for R-type and I-type; instr[30] selects SUB (R only) and arithmetic shift.
    always_comb begin
        alu_b = (opcode == OP_R) ? rs2_val : imm_i;
        shamt = alu_b[4:0];
        case (funct3)
            3'd0:    alu_res = ((opcode == OP_R) && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_res = rs1_val << shamt;
            3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_res = {31'd0, rs1_val < alu_b};
            3'd4:    alu_res = rs1_val ^ alu_b;
            3'd5:    alu_res = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6:    alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch condition; reserved funct3 codes never branch.
    always_comb begin
        case (funct3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    br_taken = (rs1_val < rs2_val);
            3'd7:    br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Control: next PC, writeback select and store enable; unknown opcodes fall through as NOP.
    always_comb begin
        pc_next   = pc_plus4;
        rd_we     = 1'b0;
        rd_data   = alu_res;
        dmem_we   = 1'b0;
        dmem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
        case (opcode)
            OP_R, OP_I: rd_we = 1'b1;
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    rd_we   = 1'b1;
                    rd_data = dmem_rdata;
                end
            end
            OP_STORE:  dmem_we = (funct3 == 3'b010);
            OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = pc_plus4;
                    pc_next = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'd0;
        else      pc <= pc_next;
    end
endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed programs with hand-derived
// results, then a random program checked against an instruction-level model.
module tb_processor;
    localparam int unsigned IMEM = 256;
    localparam int unsigned DMEM = 256;

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
        K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
        K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD
    } kind_t;

    typedef struct {
        kind_t       k;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    processor #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (.clk(clk), .rst(rst));

    int n_cmp = 0;
    int n_err = 0;

    ins_t        prog [IMEM];
    logic [31:0] m_reg [32];
    logic [31:0] m_dmem [DMEM];
    logic [31:0] s_reg [32];
    logic [31:0] s_dmem [DMEM];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(kind_t k, int rd, int rs1, int rs2, logic [31:0] imm);
        ins_t x;
        x.k = k; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
        return x;
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Small assembler from instruction records to machine words.
    function automatic logic [31:0] encode(ins_t x);
        logic [11:0] i12;
        logic [20:0] j21;
        i12 = x.imm[11:0];
        j21 = x.imm[20:0];
        case (x.k)
            K_ADD:   return enc_r(7'h00, x.rs2, x.rs1, 3'd0, x.rd);
            K_SUB:   return enc_r(7'h20, x.rs2, x.rs1, 3'd0, x.rd);
            K_SLL:   return enc_r(7'h00, x.rs2, x.rs1, 3'd1, x.rd);
            K_SLT:   return enc_r(7'h00, x.rs2, x.rs1, 3'd2, x.rd);
            K_SLTU:  return enc_r(7'h00, x.rs2, x.rs1, 3'd3, x.rd);
            K_XOR:   return enc_r(7'h00, x.rs2, x.rs1, 3'd4, x.rd);
            K_SRL:   return enc_r(7'h00, x.rs2, x.rs1, 3'd5, x.rd);
            K_SRA:   return enc_r(7'h20, x.rs2, x.rs1, 3'd5, x.rd);
            K_OR:    return enc_r(7'h00, x.rs2, x.rs1, 3'd6, x.rd);
            K_AND:   return enc_r(7'h00, x.rs2, x.rs1, 3'd7, x.rd);
            K_ADDI:  return enc_i(i12, x.rs1, 3'd0, x.rd, 7'b0010011);
            K_SLTI:  return enc_i(i12, x.rs1, 3'd2, x.rd, 7'b0010011);
            K_SLTIU: return enc_i(i12, x.rs1, 3'd3, x.rd, 7'b0010011);
            K_XORI:  return enc_i(i12, x.rs1, 3'd4, x.rd, 7'b0010011);
            K_ORI:   return enc_i(i12, x.rs1, 3'd6, x.rd, 7'b0010011);
            K_ANDI:  return enc_i(i12, x.rs1, 3'd7, x.rd, 7'b0010011);
            K_SLLI:  return enc_i(i12, x.rs1, 3'd1, x.rd, 7'b0010011);
            K_SRLI:  return enc_i(i12, x.rs1, 3'd5, x.rd, 7'b0010011);
            K_SRAI:  return enc_i(i12, x.rs1, 3'd5, x.rd, 7'b0010011);
            K_LW:    return enc_i(i12, x.rs1, 3'd2, x.rd, 7'b0000011);
            K_SW:    return {i12[11:5], x.rs2, x.rs1, 3'd2, i12[4:0], 7'b0100011};
            K_BEQ:   return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd0);
            K_BNE:   return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd1);
            K_BLT:   return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd4);
            K_BGE:   return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd5);
            K_BLTU:  return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd6);
            K_BGEU:  return enc_b(x.imm[12:0], x.rs2, x.rs1, 3'd7);
            K_JAL:   return {j21[20], j21[10:1], j21[11], j21[19:12], x.rd, 7'b1101111};
            K_JALR:  return enc_i(i12, x.rs1, 3'd0, x.rd, 7'b1100111);
            K_LUI:   return {x.imm[31:12], x.rd, 7'b0110111};
            K_AUIPC: return {x.imm[31:12], x.rd, 7'b0010111};
            default: return x.imm;
        endcase
    endfunction

    // Instruction-level reference: executes one record from prog[] on the model state.
    task automatic model_step();
        ins_t        x;
        logic [31:0] a, b, res, npc, ea;
        bit          wb, tk;
        if ((m_pc >> 2) < IMEM) x = prog[int'(m_pc >> 2)];
        else                    x = mk(K_ADDI, 0, 0, 0, 32'd0);
        a = m_reg[x.rs1]; b = m_reg[x.rs2];
        npc = m_pc + 32'd4; wb = 1'b1; tk = 1'b0; res = 32'd0;
        ea = a + x.imm;
        case (x.k)
            K_ADD:   res = a + b;
            K_SUB:   res = a - b;
            K_SLL:   res = a << b[4:0];
            K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
            K_XOR:   res = a ^ b;
            K_SRL:   res = a >> b[4:0];
            K_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
            K_OR:    res = a | b;
            K_AND:   res = a & b;
            K_ADDI:  res = a + x.imm;
            K_SLTI:  res = ($signed(a) < $signed(x.imm)) ? 32'd1 : 32'd0;
            K_SLTIU: res = (a < x.imm) ? 32'd1 : 32'd0;
            K_XORI:  res = a ^ x.imm;
            K_ORI:   res = a | x.imm;
            K_ANDI:  res = a & x.imm;
            K_SLLI:  res = a << x.imm[4:0];
            K_SRLI:  res = a >> x.imm[4:0];
            K_SRAI:  res = $unsigned($signed(a) >>> x.imm[4:0]);
            K_LW:    res = ((ea >> 2) < DMEM) ? m_dmem[int'(ea >> 2)] : 32'd0;
            K_SW: begin
                wb = 1'b0;
                if ((ea >> 2) < DMEM) m_dmem[int'(ea >> 2)] = b;
            end
            K_BEQ:   begin wb = 1'b0; tk = (a == b); end
            K_BNE:   begin wb = 1'b0; tk = (a != b); end
            K_BLT:   begin wb = 1'b0; tk = ($signed(a) < $signed(b)); end
            K_BGE:   begin wb = 1'b0; tk = ($signed(a) >= $signed(b)); end
            K_BLTU:  begin wb = 1'b0; tk = (a < b); end
            K_BGEU:  begin wb = 1'b0; tk = (a >= b); end
            K_JAL:   begin res = m_pc + 32'd4; npc = m_pc + x.imm; end
            K_JALR:  begin res = m_pc + 32'd4; npc = ea & 32'hFFFF_FFFE; end
            K_LUI:   res = x.imm;
            K_AUIPC: res = m_pc + x.imm;
            default: wb = 1'b0;
        endcase
        if (tk) npc = m_pc + x.imm;
        if (wb && (x.rd != 5'd0)) m_reg[x.rd] = res;
        m_pc = npc;
    endtask

    function automatic ins_t rand_ins();
        ins_t        x;
        logic [11:0] t12;
        logic [31:0] t;
        int          off;
        x.k   = kind_t'($urandom_range(0, 31));
        x.rd  = 5'($urandom_range(0, 7));
        x.rs1 = 5'($urandom_range(0, 7));
        x.rs2 = 5'($urandom_range(0, 7));
        t12   = 12'($urandom_range(0, 4095));
        x.imm = {{20{t12[11]}}, t12};
        t     = $urandom();
        off   = int'($urandom_range(0, 9)) - 3;
        case (x.k)
            K_SLLI, K_SRLI: x.imm = 32'($urandom_range(0, 31));
            K_SRAI: x.imm = 32'h400 | 32'($urandom_range(0, 31));
            K_LW, K_SW: begin x.rs1 = 5'd0; x.imm = 32'($urandom_range(0, 1203)); end
            K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_JAL: x.imm = 32'(off * 4);
            K_JALR: begin x.rs1 = 5'd0; x.imm = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 1)); end
            K_LUI, K_AUIPC: x.imm = {t[31:12], 12'd0};
            K_BAD: x.imm = {t[31:7], 7'h7F};
            default: ;
        endcase
        return x;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < IMEM; i++) prog[i] = mk(K_ADDI, 0, 0, 0, 32'd0);
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        for (int i = 0; i < DMEM; i++) m_dmem[i] = 32'd0;
        m_pc = 32'd0;
    endtask

    // Hold reset across one rising edge, preload the DUT from the model state, release.
    task automatic start();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < IMEM; i++) dut.inst_mem_i.mem[i] = encode(prog[i]);
        for (int i = 0; i < 32; i++) dut.reg_file_i.reg_mem[i] = m_reg[i];
        for (int i = 0; i < DMEM; i++) dut.data_mem_i.data_mem[i] = m_dmem[i];
        m_pc = 32'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.reg_file_i.reg_mem[i];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset with no clock edge yet
        #2 rst = 1'b0;
        #1 check("reset_pc_async", dut.pc, 32'd0);

        // add x3,x4,x2 from a raw word; x3 untouched while in reset
        clear_model();
        m_reg[2] = 32'd7; m_reg[4] = 32'd5; m_reg[3] = 32'hA5;
        start();
        check("no_wb_in_reset", rf(3), 32'hA5);
        rst = 1'b0;
        dut.inst_mem_i.mem[0] = 32'h002201B3;
        @(negedge clk);
        check("reset_pc_held", dut.pc, 32'd0);
        rst = 1'b1;
        step(1);
        check("add_x3", rf(3), 32'd12);
        check("add_pc", dut.pc, 32'd4);

        // sub / slt
        clear_model();
        m_reg[1] = 32'd10; m_reg[2] = 32'd3;
        prog[0] = mk(K_SUB, 5, 1, 2, 32'd0);
        prog[1] = mk(K_SLT, 6, 2, 1, 32'd0);
        prog[2] = mk(K_SUB, 7, 2, 1, 32'd0);
        start();
        step(3);
        check("sub_x5", rf(5), 32'd7);
        check("slt_x6", rf(6), 32'd1);
        check("sub_x7", rf(7), 32'hFFFF_FFF9);
        check("sub_pc", dut.pc, 32'd12);

        // load/store, low address bits ignored, out-of-range access
        clear_model();
        m_dmem[2] = 32'hDEAD_BEEF; m_dmem[3] = 32'h1234_5678;
        m_reg[1] = 32'd4; m_reg[9] = 32'h1111;
        prog[0] = mk(K_LW, 8, 1, 0, 32'd4);
        prog[1] = mk(K_SW, 0, 0, 8, 32'd0);
        prog[2] = mk(K_LW, 9, 0, 0, 32'd1024);
        prog[3] = mk(K_SW, 0, 0, 1, 32'd1024);
        prog[4] = mk(K_LW, 10, 1, 0, 32'd9);
        start();
        step(2);
        check("lw_x8", rf(8), 32'hDEAD_BEEF);
        check("sw_dmem0", dut.data_mem_i.data_mem[0], 32'hDEAD_BEEF);
        step(3);
        check("lw_oor_zero", rf(9), 32'd0);
        check("sw_oor_dropped", dut.data_mem_i.data_mem[0], 32'hDEAD_BEEF);
        check("lw_unaligned", rf(10), 32'h1234_5678);

        // beq taken skips, bne not taken
        clear_model();
        m_reg[1] = 32'd9; m_reg[2] = 32'd9; m_reg[10] = 32'h55;
        prog[0] = mk(K_BEQ, 0, 1, 2, 32'd8);
        prog[1] = mk(K_ADDI, 10, 0, 0, 32'd1);
        prog[2] = mk(K_ADDI, 11, 0, 0, 32'd2);
        start();
        step(1);
        check("beq_pc", dut.pc, 32'd8);
        step(1);
        check("beq_after_pc", dut.pc, 32'd12);
        check("beq_x11", rf(11), 32'd2);
        check("beq_skipped_x10", rf(10), 32'h55);
        prog[0] = mk(K_BNE, 0, 1, 2, 32'd8);
        start();
        step(1);
        check("bne_pc", dut.pc, 32'd4);

        // x0 write ignored and x0 reads as 0; jal link and target
        clear_model();
        m_reg[12] = 32'h77;
        prog[0] = mk(K_ADDI, 0, 0, 0, 32'd5);
        prog[2] = mk(K_JAL, 1, 0, 0, 32'd12);
        prog[5] = mk(K_ADD, 12, 0, 0, 32'd0);
        start();
        rst = 1'b0;
        dut.reg_file_i.reg_mem[0] = 32'hBAD;
        rst = 1'b1;
        step(3);
        check("jal_x1", rf(1), 32'd12);
        check("jal_pc", dut.pc, 32'd20);
        step(1);
        check("x0_read_zero", rf(12), 32'd0);
        check("x0_not_written", rf(0), 32'hBAD);

        // Fetch beyond instruction memory runs as NOP
        clear_model();
        m_reg[5] = 32'h5A5A;
        prog[0] = mk(K_JAL, 0, 0, 0, 32'd1024);
        start();
        step(1);
        check("oor_fetch_pc", dut.pc, 32'd1024);
        step(1);
        check("oor_nop_pc", dut.pc, 32'd1028);
        check("oor_nop_x5", rf(5), 32'h5A5A);

        // Signed/unsigned edges, immediates, upper immediates, jalr, bltu
        clear_model();
        m_reg[1] = 32'h8000_0000; m_reg[2] = 32'd1;
        prog[0]  = mk(K_SRA, 3, 1, 2, 32'd0);
        prog[1]  = mk(K_SRL, 4, 1, 2, 32'd0);
        prog[2]  = mk(K_SLTU, 5, 2, 1, 32'd0);
        prog[3]  = mk(K_SLT, 6, 2, 1, 32'd0);
        prog[4]  = mk(K_SRAI, 7, 1, 0, 32'h41F);
        prog[5]  = mk(K_ADDI, 8, 1, 0, 32'hFFFF_FFFF);
        prog[6]  = mk(K_LUI, 9, 0, 0, 32'hABCD_E000);
        prog[7]  = mk(K_AUIPC, 10, 0, 0, 32'h0000_1000);
        prog[8]  = mk(K_JALR, 11, 0, 0, 32'h41);
        prog[16] = mk(K_BLTU, 0, 2, 1, 32'd8);
        start();
        step(10);
        check("sra_x3", rf(3), 32'hC000_0000);
        check("srl_x4", rf(4), 32'h4000_0000);
        check("sltu_x5", rf(5), 32'd1);
        check("slt_x6", rf(6), 32'd0);
        check("srai_x7", rf(7), 32'hFFFF_FFFF);
        check("addi_x8", rf(8), 32'h7FFF_FFFF);
        check("lui_x9", rf(9), 32'hABCD_E000);
        check("auipc_x10", rf(10), 32'h0000_101C);
        check("jalr_x11", rf(11), 32'd36);
        check("bltu_pc", dut.pc, 32'h48);

        // Random program against the reference model, with a mid-program reset and rerun
        clear_model();
        for (int i = 1; i < 32; i++) m_reg[i] = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
        for (int i = 0; i < DMEM; i++) m_dmem[i] = $urandom();
        for (int i = 0; i < 64; i++) prog[i] = rand_ins();
        s_reg = m_reg;
        s_dmem = m_dmem;
        start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            model_step();
            check("rand_pc_a", dut.pc, m_pc);
        end
        #2 rst = 1'b0;
        #1 check("midrst_pc", dut.pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) check("midrst_reg", rf(i), m_reg[i]);
        for (int i = 0; i < DMEM; i++) check("midrst_dmem", dut.data_mem_i.data_mem[i], m_dmem[i]);
        m_reg = s_reg;
        m_dmem = s_dmem;
        start();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            model_step();
            check("rand_pc_b", dut.pc, m_pc);
        end
        for (int i = 0; i < 32; i++) check("rand_final_reg", rf(i), m_reg[i]);
        for (int i = 0; i < DMEM; i++) check("rand_final_dmem", dut.data_mem_i.data_mem[i], m_dmem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 IMEM_DEPTH, default 256: instruction memory depth in 32-bit words.
REQ-002 DMEM_DEPTH, default 256: data memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (rst=0 resets, rst=1 runs).
REQ-005 No other ports; state is observed and preloaded hierarchically.

Function
REQ-006 Single-cycle RV32I subset: fetch, decode, execute, memory, writeback complete in one clk cycle; one instruction retires per rising edge while rst=1.
REQ-007 Hierarchy: instance inst_mem_i with array mem[0:IMEM_DEPTH-1] of 32 bits; instance reg_file_i with array reg_mem[0:31] of 32 bits; instance data_mem_i with array data_mem[0:DMEM_DEPTH-1] of 32 bits. All three are preloadable with $readmemb and dumpable with $writememh.
REQ-008 PC is 32-bit and byte-addressed; instruction = mem[PC[31:2]]; PC out of range reads 32'h00000013 (NOP).
REQ-009 R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND per funct3/funct7[5].
REQ-010 I-type ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; 12-bit immediate sign-extended; shift amount = imm[4:0].
REQ-011 LW (0000011, funct3=010): rd <= data_mem[(rs1+imm)[31:2]].
REQ-012 SW (0100011, funct3=010): data_mem[(rs1+imm)[31:2]] <= rs2 on rising edge.
REQ-013 Data accesses are word-only; low two address bits ignored; out-of-range loads return 0; out-of-range stores are dropped.
REQ-014 Branches (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU; taken -> PC <= PC+B-imm, else PC+4.
REQ-015 JAL: rd <= PC+4, PC <= PC+J-imm. JALR: rd <= PC+4, PC <= (rs1+imm) & ~1.
REQ-016 LUI: rd <= {imm[31:12],12'b0}. AUIPC: rd <= PC+{imm[31:12],12'b0}.
REQ-017 Register file: two combinational read ports, one write port written on rising edge; reads of x0 return 0; writes to x0 ignored.
REQ-018 Arithmetic is 32-bit modulo 2^32; overflow ignored; SLT/BLT signed, SLTU/BLTU unsigned.
REQ-019 Unsupported opcodes execute as NOP: no register or memory write, PC <= PC+4.
REQ-020 Instruction memory is read-only during operation.

Reset
REQ-021 rst=0 forces PC to 0 immediately (asynchronous), independent of clk.
REQ-022 While rst=0: no register-file or data-memory writes occur.
REQ-023 Reset does not clear reg_mem, data_mem or mem; preloaded contents survive reset.
REQ-024 First instruction executed is mem[0], retired on the first rising edge with rst=1.
REQ-025 Reset asserted mid-program: PC returns to 0; any instruction in that cycle does not write back.

Verification
REQ-026 reg_mem x2=7, x4=5; mem[0]=32'h002201B3 (add x3,x4,x2); release rst -> after 1 edge x3=12, PC=4.
REQ-027 x1=10, x2=3; sub x5,x1,x2 then slt x6,x2,x1 -> x5=7, x6=1; sub x7,x2,x1 -> x7=32'hFFFFFFF9.
REQ-028 data_mem[2]=32'hDEADBEEF, x1=4; lw x8,4(x1) -> x8=32'hDEADBEEF; sw x8,0(x0) -> data_mem[0]=32'hDEADBEEF.
REQ-029 x1=x2=9; beq x1,x2,+8 at PC=0 -> next PC=8, skipped instruction has no effect; bne same operands -> PC=4.
REQ-030 addi x0,x0,5 -> x0 remains 0; jal x1,+12 at PC=8 -> x1=12, PC=20.
REQ-031 Assert rst=0 between clock edges mid-program -> PC=0 at once, register/memory contents unchanged; rerun reproduces the same final state.
